// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared types and bit positions for the MMU table walker
package mmu_pkg;

  typedef enum logic [1:0] {
    INVALID = 2'b00,
    PAGE    = 2'b01,
    TABLE   = 2'b10,
    RSVD    = 2'b11
  } desc_type_e;

  typedef enum logic [2:0] {
    IDLE,
    L1_REQ,
    L2_REQ,
    UPD_REQ,
    DONE
  } walk_state_e;

  localparam int DESC_DT_LSB   = 0;
  localparam int DESC_WP_BIT   = 2;
  localparam int DESC_U_BIT    = 3;
  localparam int DESC_M_BIT    = 4;
  localparam int DESC_BASE_LSB = 12;

  localparam int MMUSR_B_BIT = 15;
  localparam int MMUSR_W_BIT = 10;
  localparam int MMUSR_I_BIT = 9;
  localparam int MMUSR_N_LSB = 0;

  localparam int TC_E   = 31;
  localparam int TC_SRE = 25;

  function automatic logic [15:0] mk_mmusr(input logic b, input logic w,
                                           input logic i, input logic [2:0] n);
    logic [15:0] sr;
    sr                 = '0;
    sr[MMUSR_B_BIT]    = b;
    sr[MMUSR_W_BIT]    = w;
    sr[MMUSR_I_BIT]    = i;
    sr[MMUSR_N_LSB+:3] = n;
    return sr;
  endfunction

endpackage

// File: rtl/mmu_desc_decode.sv
// rtl/mmu_desc_decode.sv - combinational split of a 32-bit descriptor into its fields
module mmu_desc_decode
  import mmu_pkg::*;
#(
  parameter int PA_WIDTH = 32
) (
  input  logic [31:0]          desc,
  output desc_type_e           dtype,
  output logic                 wp,
  output logic                 u,
  output logic                 m,
  output logic [PA_WIDTH-13:0] base
);

  assign dtype = desc_type_e'(desc[DESC_DT_LSB+:2]);
  assign wp    = desc[DESC_WP_BIT];
  assign u     = desc[DESC_U_BIT];
  assign m     = desc[DESC_M_BIT];
  assign base  = desc[PA_WIDTH-1:DESC_BASE_LSB];

  // Reserved bits [11:5] carry no meaning for the walker.
  logic unused_bits;
  assign unused_bits = ^desc;

endmodule

// File: rtl/mmu_table_walker.sv
// rtl/mmu_table_walker.sv - two-level descriptor walker producing TLB fills, faults and MMUSR
// Optional descriptor U/M write-back is built when MMU_WALK_UM_UPDATE_EN is defined.
module mmu_table_walker
  import mmu_pkg::*;
#(
  parameter int PA_WIDTH = 32,
  parameter int VA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 walk_valid,
  output logic                 walk_ready,
  input  logic [VA_WIDTH-1:0]  walk_va,
  input  logic                 walk_rw,
  input  logic                 walk_super,
  input  logic [PA_WIDTH-1:0]  crp,
  input  logic [PA_WIDTH-1:0]  srp,
  input  logic [31:0]          tc,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [PA_WIDTH-1:0]  mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_ack,
  input  logic                 mem_err,
  input  logic [31:0]          mem_rdata,
  output logic                 fill_valid,
  output logic [VA_WIDTH-13:0] fill_vpn,
  output logic [PA_WIDTH-13:0] fill_ppn,
  output logic                 fill_wp,
  output logic                 fill_super,
  output logic                 fault_valid,
  output logic                 mmusr_valid,
  output logic [15:0]          mmusr_data
);

  localparam int PPN_W = PA_WIDTH - 12;
  localparam int VPN_W = VA_WIDTH - 12;

  walk_state_e state_q, state_d;

  logic [VPN_W-1:0] vpn_q;
  logic             rw_q;
  logic             super_q;
  logic [PPN_W-1:0] root_q;
  logic [PPN_W-1:0] l2_base_q;
  logic             wp_acc_q;
  logic             fault_q;

  desc_type_e       d_type;
  logic             d_wp, d_u, d_m;
  logic [PPN_W-1:0] d_base;

  mmu_desc_decode #(.PA_WIDTH(PA_WIDTH)) u_decode (
    .desc  (mem_rdata),
    .dtype (d_type),
    .wp    (d_wp),
    .u     (d_u),
    .m     (d_m),
    .base  (d_base)
  );

  logic [9:0]          idx1, idx2;
  logic [PPN_W-1:0]    root_sel;
  logic [PPN_W-1:0]    ident_ppn;
  logic [PPN_W-1:0]    early_ppn;
  logic [PA_WIDTH-1:0] l1_addr, l2_addr;

  assign idx1      = vpn_q[VPN_W-1:VPN_W-10];
  assign idx2      = vpn_q[9:0];
  assign root_sel  = (walk_super && tc[TC_SRE]) ? srp[PA_WIDTH-1:12] : crp[PA_WIDTH-1:12];
  assign ident_ppn = PPN_W'(walk_va[VA_WIDTH-1:12]);
  assign early_ppn = {d_base[PPN_W-1:10], idx2};
  assign l1_addr   = {root_q, 12'h000} + {{(PA_WIDTH-12){1'b0}}, idx1, 2'b00};
  assign l2_addr   = {l2_base_q, 12'h000} + {{(PA_WIDTH-12){1'b0}}, idx2, 2'b00};

  // fin_* describes the result registered on entry to DONE; hit_* a successful final level.
  logic             fin, fin_fault, fin_b, fin_i, fin_w, fin_wp;
  logic [2:0]       fin_n;
  logic [PPN_W-1:0] fin_ppn;
  logic             hit, hit_wp;
  logic [2:0]       hit_n;
  logic [PPN_W-1:0] hit_ppn;
  logic             l2_load;

`ifdef MMU_WALK_UM_UPDATE_EN
  logic                upd_load;
  logic [PA_WIDTH-1:0] upd_addr_q;
  logic [31:0]         upd_data_q;
  logic [PPN_W-1:0]    pend_ppn_q;
  logic                pend_wp_q;
  logic [2:0]          pend_n_q;
`endif

  always_comb begin
    state_d    = state_q;
    walk_ready = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    fin        = 1'b0;
    fin_fault  = 1'b0;
    fin_b      = 1'b0;
    fin_i      = 1'b0;
    fin_w      = 1'b0;
    fin_wp     = 1'b0;
    fin_n      = 3'd0;
    fin_ppn    = '0;
    hit        = 1'b0;
    hit_wp     = 1'b0;
    hit_n      = 3'd0;
    hit_ppn    = '0;
    l2_load    = 1'b0;
`ifdef MMU_WALK_UM_UPDATE_EN
    upd_load   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        walk_ready = 1'b1;
        if (walk_valid) begin
          if (!tc[TC_E]) begin
            state_d = DONE;
            fin     = 1'b1;
            fin_ppn = ident_ppn;
          end else begin
            state_d = L1_REQ;
          end
        end
      end

      L1_REQ: begin
        mem_req  = 1'b1;
        mem_addr = l1_addr;
        if (mem_ack) begin
          if (mem_err) begin
            state_d = DONE; fin = 1'b1; fin_fault = 1'b1; fin_b = 1'b1; fin_n = 3'd1;
          end else if (d_type == TABLE) begin
            state_d = L2_REQ;
            l2_load = 1'b1;
          end else if (d_type == PAGE) begin
            hit = 1'b1; hit_ppn = early_ppn; hit_wp = d_wp; hit_n = 3'd1;
          end else begin
            state_d = DONE; fin = 1'b1; fin_fault = 1'b1; fin_i = 1'b1; fin_n = 3'd1;
          end
        end
      end

      L2_REQ: begin
        mem_req  = 1'b1;
        mem_addr = l2_addr;
        if (mem_ack) begin
          if (mem_err) begin
            state_d = DONE; fin = 1'b1; fin_fault = 1'b1; fin_b = 1'b1; fin_n = 3'd2;
          end else if (d_type == PAGE) begin
            hit = 1'b1; hit_ppn = d_base; hit_wp = wp_acc_q | d_wp; hit_n = 3'd2;
          end else begin
            state_d = DONE; fin = 1'b1; fin_fault = 1'b1; fin_i = 1'b1; fin_n = 3'd2;
          end
        end
      end

`ifdef MMU_WALK_UM_UPDATE_EN
      UPD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = upd_addr_q;
        if (mem_ack) begin
          state_d = DONE;
          fin     = 1'b1;
          fin_n   = pend_n_q;
          if (mem_err) begin
            fin_fault = 1'b1; fin_b = 1'b1;
          end else begin
            fin_ppn = pend_ppn_q; fin_wp = pend_wp_q;
          end
        end
      end
`endif

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A write-protect fault wins over the descriptor update: nothing is written back.
    if (hit) begin
      if (rw_q && hit_wp) begin
        state_d = DONE; fin = 1'b1; fin_fault = 1'b1; fin_w = 1'b1; fin_n = hit_n;
      end
`ifdef MMU_WALK_UM_UPDATE_EN
      else if (!d_u || (rw_q && !d_m)) begin
        state_d  = UPD_REQ;
        upd_load = 1'b1;
      end
`endif
      else begin
        state_d = DONE; fin = 1'b1; fin_ppn = hit_ppn; fin_wp = hit_wp; fin_n = hit_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vpn_q      <= '0;
      rw_q       <= 1'b0;
      super_q    <= 1'b0;
      root_q     <= '0;
      l2_base_q  <= '0;
      wp_acc_q   <= 1'b0;
      fault_q    <= 1'b0;
      fill_vpn   <= '0;
      fill_ppn   <= '0;
      fill_wp    <= 1'b0;
      fill_super <= 1'b0;
      mmusr_data <= '0;
    end else begin
      state_q <= state_d;
      if (walk_valid && walk_ready) begin
        vpn_q   <= walk_va[VA_WIDTH-1:12];
        rw_q    <= walk_rw;
        super_q <= walk_super;
        root_q  <= root_sel;
      end
      if (l2_load) begin
        l2_base_q <= d_base;
        wp_acc_q  <= d_wp;
      end
      if (fin) begin
        fault_q    <= fin_fault;
        mmusr_data <= mk_mmusr(fin_b, fin_w, fin_i, fin_n);
        if (!fin_fault) begin
          // The identity path finishes on the accept edge, before vpn_q/super_q are loaded.
          fill_vpn   <= (state_q == IDLE) ? walk_va[VA_WIDTH-1:12] : vpn_q;
          fill_super <= (state_q == IDLE) ? walk_super : super_q;
          fill_ppn   <= fin_ppn;
          fill_wp    <= fin_wp;
        end
      end
    end
  end

`ifdef MMU_WALK_UM_UPDATE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_addr_q <= '0;
      upd_data_q <= '0;
      pend_ppn_q <= '0;
      pend_wp_q  <= 1'b0;
      pend_n_q   <= 3'd0;
    end else if (upd_load) begin
      upd_addr_q <= mem_addr;
      upd_data_q <= mem_rdata | (32'd1 << DESC_U_BIT) | (rw_q ? (32'd1 << DESC_M_BIT) : 32'd0);
      pend_ppn_q <= hit_ppn;
      pend_wp_q  <= hit_wp;
      pend_n_q   <= hit_n;
    end
  end

  assign mem_we    = (state_q == UPD_REQ);
  assign mem_wdata = mem_we ? upd_data_q : 32'd0;
`else
  assign mem_we    = 1'b0;
  assign mem_wdata = 32'd0;

  logic unused_um;
  assign unused_um = d_u ^ d_m;
`endif

  assign fill_valid  = (state_q == DONE) && !fault_q;
  assign fault_valid = (state_q == DONE) && fault_q;
  assign mmusr_valid = (state_q == DONE);

  logic unused_inputs;
  assign unused_inputs = ^{walk_va[11:0], crp[11:0], srp[11:0], tc[30:26], tc[24:0]};

endmodule

// File: tb/tb_mmu_table_walker.sv
// tb/tb_mmu_table_walker.sv - directed table-driven bench for mmu_table_walker
module tb_mmu_table_walker;

  logic        clk = 1'b0;
  logic        rst;
  logic        walk_valid, walk_ready;
  logic [31:0] walk_va;
  logic        walk_rw, walk_super;
  logic [31:0] crp, srp, tc;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0, mem_err = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        fill_valid;
  logic [19:0] fill_vpn, fill_ppn;
  logic        fill_wp, fill_super, fault_valid, mmusr_valid;
  logic [15:0] mmusr_data;

  always #5 clk = ~clk;

  mmu_table_walker dut (
    .clk(clk), .rst(rst),
    .walk_valid(walk_valid), .walk_ready(walk_ready), .walk_va(walk_va),
    .walk_rw(walk_rw), .walk_super(walk_super),
    .crp(crp), .srp(srp), .tc(tc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata),
    .fill_valid(fill_valid), .fill_vpn(fill_vpn), .fill_ppn(fill_ppn),
    .fill_wp(fill_wp), .fill_super(fill_super),
    .fault_valid(fault_valid), .mmusr_valid(mmusr_valid), .mmusr_data(mmusr_data)
  );

  // Memory responder: zero-wait acks from a two-entry map, or manual drive.
  logic        mem_auto = 1'b1;
  logic        man_ack = 1'b0, man_err = 1'b0;
  logic [31:0] man_rdata = '0;
  logic [31:0] m_a1, m_d1, m_a2, m_d2;
  logic        m_e1, m_e2;
  int          req_cnt = 0, wr_cnt = 0, bad_addr = 0;
  logic [31:0] wr_addr = '0, wr_data = '0;

  always @(negedge clk) begin
    if (mem_req) req_cnt++;
    if (!mem_auto) begin
      mem_ack = man_ack; mem_err = man_err; mem_rdata = man_rdata;
    end else if (mem_req) begin
      mem_ack = 1'b1;
      if (mem_we) begin
        mem_err = 1'b0; mem_rdata = '0; wr_cnt++; wr_addr = mem_addr; wr_data = mem_wdata;
      end else if (mem_addr == m_a1) begin
        mem_rdata = m_d1; mem_err = m_e1;
      end else if (mem_addr == m_a2) begin
        mem_rdata = m_d2; mem_err = m_e2;
      end else begin
        mem_rdata = 32'hDEAD_BEE3; mem_err = 1'b0; bad_addr++;
      end
    end else begin
      mem_ack = 1'b0; mem_err = 1'b0;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] va;
    logic        rw, sup;
    logic [31:0] tcv, srpv;
    logic [31:0] a1, d1;
    logic        e1;
    logic [31:0] a2, d2;
    logic        e2;
    logic        fault;
    logic [19:0] ppn;
    logic        wp;
    logic [15:0] sr;
    int          lat;
    logic        upd;
    logic [31:0] waddr, wdata;
  } vec_t;

  localparam logic [31:0] TC_ON = 32'h8000_0000;
  localparam logic [31:0] CRP   = 32'h0001_0000;

  task automatic run_vec(input int id, input vec_t v);
    int   cyc, req0, wr0, bad0, exp_lat, exp_upd;
    @(negedge clk);
    m_a1 = v.a1; m_d1 = v.d1; m_e1 = v.e1;
    m_a2 = v.a2; m_d2 = v.d2; m_e2 = v.e2;
    tc = v.tcv; srp = v.srpv; crp = CRP;
    walk_va = v.va; walk_rw = v.rw; walk_super = v.sup; walk_valid = 1'b1;
    req0 = req_cnt; wr0 = wr_cnt; bad0 = bad_addr;
`ifdef MMU_WALK_UM_UPDATE_EN
    exp_upd = int'(v.upd);
`else
    exp_upd = 0;
`endif
    exp_lat = v.lat + exp_upd;
    chk($sformatf("v%0d ready_idle", id), 32'(walk_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    walk_valid = 1'b0;
    cyc = 1;
    while (!mmusr_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d mmusr_valid", id), 32'(mmusr_valid), 32'd1);
    chk($sformatf("v%0d latency", id), 32'(cyc), 32'(exp_lat));
    chk($sformatf("v%0d fill_valid", id), 32'(fill_valid), 32'(!v.fault));
    chk($sformatf("v%0d fault_valid", id), 32'(fault_valid), 32'(v.fault));
    chk($sformatf("v%0d mmusr_data", id), 32'(mmusr_data), 32'(v.sr));
    if (!v.fault) begin
      chk($sformatf("v%0d fill_ppn", id), 32'(fill_ppn), 32'(v.ppn));
      chk($sformatf("v%0d fill_wp", id), 32'(fill_wp), 32'(v.wp));
      chk($sformatf("v%0d fill_vpn", id), 32'(fill_vpn), 32'(v.va[31:12]));
      chk($sformatf("v%0d fill_super", id), 32'(fill_super), 32'(v.sup));
    end
    @(negedge clk);
    chk($sformatf("v%0d pulse_end", id), 32'({fill_valid, fault_valid, mmusr_valid}), 32'd0);
    chk($sformatf("v%0d ready_after", id), 32'(walk_ready), 32'd1);
    chk($sformatf("v%0d mem_reqs", id), 32'(req_cnt - req0), 32'(int'(v.sr[2:0]) + exp_upd));
    chk($sformatf("v%0d bad_addr", id), 32'(bad_addr - bad0), 32'd0);
    chk($sformatf("v%0d writes", id), 32'(wr_cnt - wr0), 32'(exp_upd));
    if (exp_upd != 0) begin
      chk($sformatf("v%0d wr_addr", id), wr_addr, v.waddr);
      chk($sformatf("v%0d wr_data", id), wr_data, v.wdata);
    end
  endtask

  vec_t vecs[14];
  logic stray_pulse;

  initial begin
    // Fields: va rw sup tc srp | a1 d1 e1 | a2 d2 e2 | fault ppn wp sr lat | upd waddr wdata
    vecs[0]  = '{32'h0040_3123, 1'b0, 1'b0, TC_ON, 32'h0, 32'h0001_0004, 32'h0002_0002, 1'b0,
                 32'h0002_000C, 32'h0ABC_D001, 1'b0, 1'b0, 20'h0ABCD, 1'b0, 16'h0002, 3,
                 1'b1, 32'h0002_000C, 32'h0ABC_D009};
    vecs[1]  = '{32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0,
                 32'h0, 32'h0, 1'b0, 1'b0, 20'h12345, 1'b0, 16'h0000, 1, 1'b0, 32'h0, 32'h0};
    vecs[2]  = '{32'hFFFF_F000, 1'b1, 1'b1, 32'h0200_0000, 32'h0003_0000, 32'h0, 32'h0, 1'b0,
                 32'h0, 32'h0, 1'b0, 1'b0, 20'hFFFFF, 1'b0, 16'h0000, 1, 1'b0, 32'h0, 32'h0};
    vecs[3]  = '{32'h0040_3123, 1'b0, 1'b0, TC_ON, 32'h0, 32'h0001_0004, 32'h0000_0000, 1'b0,
                 32'h0, 32'h0, 1'b0, 1'b1, 20'h0, 1'b0, 16'h0201, 2, 1'b0, 32'h0, 32'h0};
    vecs[4]  = '{32'h0040_3123, 1'b0, 1'b0, TC_ON, 32'h0, 32'h0001_0004, 32'h0002_0002, 1'b0,
                 32'h0002_000C, 32'h0ABC_D001, 1'b1, 1'b1, 20'h0, 1'b0, 16'h8002, 3,
                 1'b0, 32'h0, 32'h0};
    vecs[5]  = '{32'h0040_3123, 1'b1, 1'b0, TC_ON, 32'h0, 32'h0001_0004, 32'h0002_0006, 1'b0,
                 32'h0002_000C, 32'h0ABC_D001, 1'b0, 1'b1, 20'h0, 1'b0, 16'h0402, 3,
                 1'b0, 32'h0, 32'h0};
    vecs[6]  = '{32'h0040_3123, 1'b0, 1'b0, TC_ON, 32'h0, 32'h0001_0004, 32'h0A40_0001, 1'b0,
                 32'h0, 32'h0, 1'b0, 1'b0, 20'h0A403, 1'b0, 16'h0001, 2,
                 1'b1, 32'h0001_0004, 32'h0A40_0009};
    vecs[7]  = '{32'h0040_3123, 1'b0, 1'b0, TC_ON, 32'h0, 32'h0001_0004, 32'h0002_0002, 1'b1,
                 32'h0, 32'h0, 1'b0, 1'b1, 20'h0, 1'b0, 16'h8001, 2, 1'b0, 32'h0, 32'h0};
    vecs[8]  = '{32'hFFC0_0000, 1'b0, 1'b1, 32'h8200_0000, 32'h0003_0ABC, 32'h0003_0FFC,
                 32'h0004_0002, 1'b0, 32'h0004_0000, 32'h1234_5005, 1'b0, 1'b0, 20'h12345,
                 1'b1, 16'h0002, 3, 1'b1, 32'h0004_0000, 32'h1234_500D};
    vecs[9]  = '{32'h0000_0000, 1'b1, 1'b1, TC_ON, 32'h0003_0000, 32'h0001_0000, 32'h0005_0002,
                 1'b0, 32'h0005_0000, 32'h0006_7019, 1'b0, 1'b0, 20'h00067, 1'b0, 16'h0002, 3,
                 1'b0, 32'h0, 32'h0};
    vecs[10] = '{32'h0040_3123, 1'b1, 1'b0, TC_ON, 32'h0, 32'h0001_0004, 32'h0002_0002, 1'b0,
                 32'h0002_000C, 32'h0ABC_D001, 1'b0, 1'b0, 20'h0ABCD, 1'b0, 16'h0002, 3,
                 1'b1, 32'h0002_000C, 32'h0ABC_D019};
    vecs[11] = '{32'h0040_3123, 1'b0, 1'b0, TC_ON, 32'h0, 32'h0001_0004, 32'h0002_0002, 1'b0,
                 32'h0002_000C, 32'h0ABC_D002, 1'b0, 1'b1, 20'h0, 1'b0, 16'h0202, 3,
                 1'b0, 32'h0, 32'h0};
    vecs[12] = '{32'h0040_3123, 1'b0, 1'b0, TC_ON, 32'h0, 32'h0001_0004, 32'h0002_0003, 1'b0,
                 32'h0, 32'h0, 1'b0, 1'b1, 20'h0, 1'b0, 16'h0201, 2, 1'b0, 32'h0, 32'h0};
    vecs[13] = '{32'h0040_3123, 1'b1, 1'b0, TC_ON, 32'h0, 32'h0001_0004, 32'h0A40_0005, 1'b0,
                 32'h0, 32'h0, 1'b0, 1'b1, 20'h0, 1'b0, 16'h0401, 2, 1'b0, 32'h0, 32'h0};

    rst = 1'b1; walk_valid = 1'b0; walk_va = '0; walk_rw = 1'b0; walk_super = 1'b0;
    crp = CRP; srp = '0; tc = '0;
    m_a1 = '0; m_d1 = '0; m_e1 = 1'b0; m_a2 = '0; m_d2 = '0; m_e2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst walk_ready", 32'(walk_ready), 32'd1);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst pulses", 32'({fill_valid, fault_valid, mmusr_valid}), 32'd0);
    chk("rst mmusr_data", 32'(mmusr_data), 32'd0);
    chk("rst fill_ppn", 32'(fill_ppn), 32'd0);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Reset while L2_REQ waits on a withheld ack, then a stray ack in IDLE.
    mem_auto = 1'b0;
    @(negedge clk);
    tc = TC_ON; crp = CRP; walk_va = 32'h0040_3123; walk_rw = 1'b0; walk_super = 1'b0;
    walk_valid = 1'b1;
    @(posedge clk);
    #1 walk_valid = 1'b0; man_ack = 1'b1; man_rdata = 32'h0002_0002; man_err = 1'b0;
    @(posedge clk);
    #1 man_ack = 1'b0;
    @(negedge clk);
    chk("l2 hold mem_req", 32'(mem_req), 32'd1);
    chk("l2 hold mem_addr", mem_addr, 32'h0002_000C);
    @(negedge clk);
    chk("l2 stable mem_addr", mem_addr, 32'h0002_000C);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midwalk rst walk_ready", 32'(walk_ready), 32'd1);
    chk("midwalk rst mem_req", 32'(mem_req), 32'd0);
    chk("midwalk rst mmusr_data", 32'(mmusr_data), 32'd0);
    @(posedge clk);
    #1 man_ack = 1'b1; man_rdata = 32'h0ABC_D001;
    @(posedge clk);
    #1 man_ack = 1'b0;
    stray_pulse = 1'b0;
    repeat (4) begin
      @(negedge clk);
      stray_pulse = stray_pulse | fill_valid | fault_valid | mmusr_valid | !walk_ready;
    end
    chk("stray ack ignored", 32'(stray_pulse), 32'd0);
    mem_auto = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmu_table_walker.md
Name: mmu_table_walker

Overview:
- Hardware table-walk engine directly downstream of the MMU control register file; consumes its CRP, SRP and TC outputs.
- On a translation miss, fetches up to two levels of 32-bit descriptors from memory and returns one of two results:
  - a TLB fill (physical page plus attributes), or
  - a fault, together with a 16-bit MMUSR status word for the register file to capture.
- Sits between the ATC/TLB miss path and the memory arbiter.

Parameters:
- PA_WIDTH, 32, physical address width; must be ≥ 24.
- VA_WIDTH, 32, virtual address width; VA split is idx1=VA[31:22], idx2=VA[21:12], offset=VA[11:0].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- walk_valid  in  1  miss request valid
- walk_ready  out  1  walker idle; request accepted on walk_valid&&walk_ready
- walk_va  in  VA_WIDTH  missing virtual address
- walk_rw  in  1  1=write access
- walk_super  in  1  supervisor access
- crp  in  PA_WIDTH  CPU root pointer
- srp  in  PA_WIDTH  supervisor root pointer
- tc  in  32  translation control; [31]=E enable, [25]=SRE
- mem_req  out  1  descriptor memory request
- mem_we  out  1  1=write-back (optional feature only)
- mem_addr  out  PA_WIDTH  word-aligned descriptor address
- mem_wdata  out  32  write-back data
- mem_ack  in  1  request complete
- mem_err  in  1  bus error, qualified by mem_ack
- mem_rdata  in  32  descriptor, valid with mem_ack
- fill_valid  out  1  one-cycle fill pulse
- fill_vpn  out  VA_WIDTH-12  VA[31:12]
- fill_ppn  out  PA_WIDTH-12  physical page number
- fill_wp  out  1  write-protect (OR of all levels)
- fill_super  out  1  tag copied from walk_super
- fault_valid  out  1  one-cycle fault pulse
- mmusr_valid  out  1  one-cycle status update pulse; coincides with fill_valid or fault_valid
- mmusr_data  out  16  [15]=B bus error, [10]=W write-protect, [9]=I invalid, [2:0]=N levels fetched

Behaviour:
- **Reset:**
  - All outputs 0 except walk_ready=1.
  - State returns to IDLE on the same edge, including mid-walk.
  - mem_req drops in the first cycle after reset.
  - A late mem_ack arriving in IDLE is ignored.
- **Root pointer selection:** srp when walk_super && tc[25]; else crp.
  - Root base = {root[PA_WIDTH-1:12], 12'h000}.
- **Descriptor format:**
  - [1:0] DT: 00 invalid, 01 page, 10 table, 11 invalid.
  - [2] WP, [3] U, [4] M.
  - [PA_WIDTH-1:12] base.
- **States:** IDLE, L1_REQ, L2_REQ, UPD_REQ, DONE.
- **IDLE:**
  - Request accepted and tc[31]=0 → DONE with identity fill: ppn = VA[PA_WIDTH-1:12], wp=0, N=0, no memory access.
  - Otherwise → L1_REQ; walk_va, walk_rw and walk_super are latched.
- **L1_REQ:**
  - mem_req=1, mem_we=0, mem_addr = root base + idx1*4.
  - mem_req and mem_addr are held stable until mem_ack; ack may arrive in the first cycle mem_req is high.
  - On ack:
    - mem_err → fault B=1.
    - DT=table → L2_REQ.
    - DT=page → early-termination 4 MiB page: ppn = {desc[PA_WIDTH-1:22], VA[21:12]}.
    - DT invalid → fault I=1.
- **L2_REQ:**
  - mem_addr = {desc1[PA_WIDTH-1:12], 12'h000} + idx2*4.
  - On ack:
    - mem_err → B.
    - DT=page → ppn = desc2[PA_WIDTH-1:12].
    - DT=table or invalid → I.
- **Write-protect:** if walk_rw && accumulated WP → fault W=1, with no fill.
- **Fault priority:** B > I > W.
- **N:** counts descriptors fetched, including the faulting one.
- **DONE:** exactly one cycle.
  - Pulses either fill_valid or fault_valid, plus mmusr_valid.
  - Then → IDLE.
- **Outputs when not valid:** fill_* and mmusr_data hold their last values.
- **walk_ready:** high only in IDLE. The consumer must accept the pulses unconditionally; there is no backpressure.
- **Latency with zero-wait memory (ack in first req cycle):**
  - Two-level fill: accept at edge 0; fill_valid in cycle 3; walk_ready in cycle 4.
  - tc[31]=0: fill_valid in cycle 1.
- **Address arithmetic:** modulo 2^PA_WIDTH; carry out of the top bit is discarded.

Optional Feature:
- Macro: MMU_WALK_UM_UPDATE_EN.
- When defined:
  - After a successful final-level fetch, the walker enters UPD_REQ if U=0, or if walk_rw=1 and M=0.
  - It writes the descriptor back with mem_we=1, the same mem_addr, and mem_wdata = desc | U | (walk_rw ? M : 0).
  - The fill is issued after that write's ack.
  - mem_err on the write-back → fault B=1, with no fill.
- When undefined:
  - UPD_REQ is not compiled.
  - mem_we is tied 0 and mem_wdata is tied 0.

Decomposition:
- Shared package mmu_pkg holds:
  - desc_type_e (INVALID, PAGE, TABLE, RSVD).
  - Descriptor bit-position constants.
  - MMUSR bit positions (B, W, I, N).
  - TC_E and TC_SRE bit indices.
  - walk_state_e.
- One natural sub-module, mmu_desc_decode: combinational decode of a 32-bit descriptor into type, wp, u, m and base.

Test Plan:
1. tc=0x8000_0000, crp=0x0001_0000, VA=0x0040_3123 read. Memory returns desc1 at 0x0001_0004 = 0x0002_0002 and desc2 at 0x0002_000C = 0x0ABC_D001 → fill_ppn=0x0ABCD, mmusr_data=0x0002, fill 3 cycles after accept.
2. tc=0: any VA → identity fill in cycle 1, mem_req never asserted, N=0.
3. desc1=0x0000_0000 → fault_valid, mmusr_data=0x0201. Repeat with mem_err=1 on L2 → mmusr_data=0x8002.
4. walk_rw=1 with WP=1 in desc1 and valid desc2 → fault W, mmusr_data=0x0402, no fill_valid.
5. Assert rst while in L2_REQ with mem_ack withheld → walk_ready=1 and mem_req=0 the next cycle. A stray ack afterwards produces no pulse.
6. MMU_WALK_UM_UPDATE_EN defined: write access with desc2 U=M=0 → memory write of desc2|0x18 to the same address, then fill.
